// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that shares one bank of JK flip-flops between NREQ requesters.
// An accepted command becomes a one-hot J/K drive, and the bank applies it on the following edge.
module jk_bank_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [WIDTH-1:0]     j_vec,
    output logic [WIDTH-1:0]     k_vec,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 err
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0]  ptr_reg;
    logic [PTRW-1:0]  ptr_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] j_reg;
    logic [WIDTH-1:0] k_reg;
    logic             err_reg;

    logic [PTRW-1:0]  cand_idx [NREQ];
    logic [PTRW-1:0]  sel;
    logic             found;
    logic             accept;
    logic [1:0]       op_sel;
    logic [IDXW-1:0]  idx_sel;
    logic             in_range;
    logic [WIDTH-1:0] onehot;

    // cand_idx[k] is the requester examined k-th in the rotating scan
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand_idx[gi] = PTRW'((int'(ptr_reg) + gi) % NREQ);
    end

    always_comb begin
        sel   = '0;
        found = 1'b0;
        // Walk from the farthest candidate back so the nearest valid one wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                sel   = cand_idx[k];
                found = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = found & ~rst & (sel == PTRW'(gi));
    end

    assign accept   = |(req_valid & req_ready);
    assign op_sel   = req_op[2*sel +: 2];
    assign idx_sel  = req_idx[IDXW*sel +: IDXW];
    assign in_range = (32'(idx_sel) < WIDTH);
    assign ptr_next = (32'(sel) == NREQ - 1) ? '0 : sel + PTRW'(1);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
        assign onehot[gi] = (idx_sel == IDXW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
            q_reg   <= '0;
            j_reg   <= '0;
            k_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            // JK rule bitwise: set where J, clear where K, toggle where both
            q_reg   <= (j_reg & ~q_reg) | (~k_reg & q_reg);
            j_reg   <= (accept && op_sel[1] && in_range) ? onehot : '0;
            k_reg   <= (accept && op_sel[0] && in_range) ? onehot : '0;
            err_reg <= accept && !in_range;
            if (accept) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    assign q     = q_reg;
    assign j_vec = j_reg;
    assign k_vec = k_reg;
    assign err   = err_reg;
    assign busy  = |(j_reg | k_reg);

endmodule
